// File: rtl/sa_pkg.sv
// Shared definitions for the complex MAC systolic cell: operating modes and
// default operand/accumulator/weight-bank sizes.
package sa_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_WBUF_DEPTH = 16;

  typedef enum logic [1:0] {
    MODE_REAL   = 2'd0,
    MODE_CMUL   = 2'd1,
    MODE_CMAC   = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

endpackage

// File: rtl/sa_cmul.sv
// Registered complex multiplier (pipeline stage 1). It returns the four
// partial products, so the cell can form the real-only product or the full
// complex product from the same registers.
module sa_cmul #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DATA_WIDTH-1:0]   a_re,
  input  logic signed [DATA_WIDTH-1:0]   a_im,
  input  logic signed [DATA_WIDTH-1:0]   b_re,
  input  logic signed [DATA_WIDTH-1:0]   b_im,
  output logic signed [2*DATA_WIDTH-1:0] p_rr,
  output logic signed [2*DATA_WIDTH-1:0] p_ii,
  output logic signed [2*DATA_WIDTH-1:0] p_ri,
  output logic signed [2*DATA_WIDTH-1:0] p_ir
);

  localparam int PW = 2 * DATA_WIDTH;

  // Full-precision signed products, registered every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else begin
      p_rr <= PW'(a_re) * PW'(b_re);
      p_ii <= PW'(a_im) * PW'(b_im);
      p_ri <= PW'(a_re) * PW'(b_im);
      p_ir <= PW'(a_im) * PW'(b_re);
    end
  end

endmodule

// File: rtl/sa_cmac_cell.sv
// Systolic complex MAC cell. The left operand is forwarded to the right
// neighbour after one cycle. Partial sums flow from up to down through a
// two-stage pipeline. Weights are held in a local bank and reused
// cyclically, one weight per weight-consuming sample.
module sa_cmac_cell
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       mode,
  input  logic                             in_valid,
  input  logic signed [DATA_WIDTH-1:0]     left_re,
  input  logic signed [DATA_WIDTH-1:0]     left_im,
  input  logic signed [ACC_WIDTH-1:0]      up_re,
  input  logic signed [ACC_WIDTH-1:0]      up_im,
  input  logic signed [DATA_WIDTH-1:0]     w_in_re,
  input  logic signed [DATA_WIDTH-1:0]     w_in_im,
  input  logic                             w_in_valid,
  output logic                             w_in_ready,
  input  logic                             w_clear,
  output logic signed [DATA_WIDTH-1:0]     right_re,
  output logic signed [DATA_WIDTH-1:0]     right_im,
  output logic                             right_valid,
  output logic signed [ACC_WIDTH-1:0]      down_re,
  output logic signed [ACC_WIDTH-1:0]      down_im,
  output logic                             down_valid,
  output logic [$clog2(WBUF_DEPTH):0]      w_count,
  output logic                             err_no_weight
);

  localparam int AW = $clog2(WBUF_DEPTH);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(WBUF_DEPTH);

  logic signed [DATA_WIDTH-1:0] bank_re [WBUF_DEPTH];
  logic signed [DATA_WIDTH-1:0] bank_im [WBUF_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          consume;
  logic          empty;
  logic          rd_wrap;
  logic signed [DATA_WIDTH-1:0] w_re;
  logic signed [DATA_WIDTH-1:0] w_im;
  mode_e         in_mode;

  logic                        s1_valid;
  mode_e                       s1_mode;
  logic signed [ACC_WIDTH-1:0] s1_up_re;
  logic signed [ACC_WIDTH-1:0] s1_up_im;
  logic signed [PW-1:0]        p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_WIDTH-1:0] e_rr, e_ii, e_ri, e_ir;
  logic signed [ACC_WIDTH-1:0] sum_re;
  logic signed [ACC_WIDTH-1:0] sum_im;

  assign in_mode    = mode_e'(mode);
  assign w_in_ready = (w_count < DEPTH_C);
  assign push       = w_in_valid && w_in_ready && !w_clear;
  assign empty      = (w_count == '0);
  assign consume    = in_valid && (in_mode != MODE_BYPASS);
  // Wrap against the count seen this cycle, so a push in the same cycle
  // does not extend the current cycle of reuse.
  assign rd_wrap    = (({1'b0, rd_ptr} + (AW+1)'(1)) == w_count);
  // An empty bank yields a zero weight.
  assign w_re       = empty ? '0 : bank_re[rd_ptr];
  assign w_im       = empty ? '0 : bank_im[rd_ptr];

  // Weight bank storage; contents survive reset and are not cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      bank_re[wr_ptr] <= w_in_re;
      bank_im[wr_ptr] <= w_in_im;
    end
  end

  // Bank pointers, fill count and the sticky missing-weight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      w_count       <= '0;
      err_no_weight <= 1'b0;
    end else if (w_clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      w_count       <= '0;
      err_no_weight <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        w_count <= w_count + (AW+1)'(1);
      end
      if (consume && !empty)
        rd_ptr <= rd_wrap ? '0 : rd_ptr + AW'(1);
      if (consume && empty)
        err_no_weight <= 1'b1;
    end
  end

  // Left operand forwarded to the right neighbour with one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      right_re    <= '0;
      right_im    <= '0;
      right_valid <= 1'b0;
    end else begin
      right_re    <= left_re;
      right_im    <= left_im;
      right_valid <= in_valid;
    end
  end

  sa_cmul #(.DATA_WIDTH(DATA_WIDTH)) u_cmul (
    .clk  (clk),
    .rst  (rst),
    .a_re (left_re),
    .a_im (left_im),
    .b_re (w_re),
    .b_im (w_im),
    .p_rr (p_rr),
    .p_ii (p_ii),
    .p_ri (p_ri),
    .p_ir (p_ir)
  );

  // Stage 1 side-band: the mode and partial sum travel with their products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_REAL;
      s1_up_re <= '0;
      s1_up_im <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_up_re <= up_re;
      s1_up_im <= up_im;
    end
  end

  // Products are sign-extended to the accumulator width; sums wrap.
  assign e_rr = ACC_WIDTH'(p_rr);
  assign e_ii = ACC_WIDTH'(p_ii);
  assign e_ri = ACC_WIDTH'(p_ri);
  assign e_ir = ACC_WIDTH'(p_ir);

  // Stage 2 sum selection per sample mode.
  always_comb begin
    sum_re = s1_up_re;
    sum_im = s1_up_im;
    case (s1_mode)
      MODE_REAL: begin
        sum_re = s1_up_re + e_rr;
        sum_im = '0;
      end
      MODE_CMUL: begin
        sum_re = e_rr - e_ii;
        sum_im = e_ri + e_ir;
      end
      MODE_CMAC: begin
        sum_re = s1_up_re + e_rr - e_ii;
        sum_im = s1_up_im + e_ri + e_ir;
      end
      default: begin
        sum_re = s1_up_re;
        sum_im = s1_up_im;
      end
    endcase
  end

  // Stage 2 register; down_* holds its last value between valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_re    <= '0;
      down_im    <= '0;
      down_valid <= 1'b0;
    end else begin
      down_valid <= s1_valid;
      if (s1_valid) begin
        down_re <= sum_re;
        down_im <= sum_im;
      end
    end
  end

endmodule

// File: tb/tb_sa_cmac_cell.sv
// Bench for sa_cmac_cell: directed vectors followed by a randomized run,
// all checked against a queue-based behavioural model of the cell.
module tb_sa_cmac_cell;

  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         mode;
  logic               in_valid;
  logic signed [15:0] left_re, left_im;
  logic signed [39:0] up_re, up_im;
  logic signed [15:0] w_in_re, w_in_im;
  logic               w_in_valid;
  logic               w_in_ready;
  logic               w_clear;
  logic signed [15:0] right_re, right_im;
  logic               right_valid;
  logic signed [39:0] down_re, down_im;
  logic               down_valid;
  logic [4:0]         w_count;
  logic               err_no_weight;

  sa_cmac_cell dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .in_valid      (in_valid),
    .left_re       (left_re),
    .left_im       (left_im),
    .up_re         (up_re),
    .up_im         (up_im),
    .w_in_re       (w_in_re),
    .w_in_im       (w_in_im),
    .w_in_valid    (w_in_valid),
    .w_in_ready    (w_in_ready),
    .w_clear       (w_clear),
    .right_re      (right_re),
    .right_im      (right_im),
    .right_valid   (right_valid),
    .down_re       (down_re),
    .down_im       (down_im),
    .down_valid    (down_valid),
    .w_count       (w_count),
    .err_no_weight (err_no_weight)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  longint mq_re[$];
  longint mq_im[$];
  int     m_rd;
  bit     m_err;
  bit     p1v;
  longint p1re, p1im;
  longint last_re, last_im;
  longint got[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  function automatic longint wrap40(input longint v);
    logic [39:0] t;
    t = v[39:0];
    return longint'($signed(t));
  endfunction

  task automatic model_reset();
    mq_re.delete();
    mq_im.delete();
    m_rd    = 0;
    m_err   = 1'b0;
    p1v     = 1'b0;
    p1re    = 0;
    p1im    = 0;
    last_re = 0;
    last_im = 0;
  endtask

  // Advance the model by one sample of the current inputs, clock the DUT,
  // then compare every output against the model.
  task automatic cycle();
    longint wr, wi, lr, li, ur, ui, rre, rim;
    bit     exp_dv;
    int     n;
    n  = mq_re.size();
    lr = longint'(left_re);
    li = longint'(left_im);
    ur = longint'(up_re);
    ui = longint'(up_im);
    wr = 0;
    wi = 0;
    if (in_valid && mode != 2'd3) begin
      if (n == 0) m_err = 1'b1;
      else begin
        wr   = mq_re[m_rd];
        wi   = mq_im[m_rd];
        m_rd = (m_rd + 1) % n;
      end
    end
    case (mode)
      2'd0:    begin rre = ur + lr*wr;         rim = 0; end
      2'd1:    begin rre = lr*wr - li*wi;      rim = lr*wi + li*wr; end
      2'd2:    begin rre = ur + lr*wr - li*wi; rim = ui + lr*wi + li*wr; end
      default: begin rre = ur;                 rim = ui; end
    endcase
    rre = wrap40(rre);
    rim = wrap40(rim);
    if (w_clear) begin
      mq_re.delete();
      mq_im.delete();
      m_rd  = 0;
      m_err = 1'b0;
    end else if (w_in_valid && n < DEPTH) begin
      mq_re.push_back(longint'(w_in_re));
      mq_im.push_back(longint'(w_in_im));
    end
    exp_dv = p1v;
    if (p1v) begin
      last_re = p1re;
      last_im = p1im;
    end
    p1v  = in_valid;
    p1re = rre;
    p1im = rim;
    lr = longint'(left_re);
    li = longint'(left_im);
    n  = in_valid ? 1 : 0;
    @(posedge clk);
    #1;
    check("right_valid", right_valid, n);
    check("right_re", right_re, lr);
    check("right_im", right_im, li);
    check("down_valid", down_valid, exp_dv);
    check("down_re", down_re, last_re);
    check("down_im", down_im, last_im);
    check("w_count", w_count, mq_re.size());
    check("w_in_ready", w_in_ready, (mq_re.size() < DEPTH) ? 1 : 0);
    check("err_no_weight", err_no_weight, m_err);
    if (down_valid) got.push_back(longint'(down_re));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_right_valid", right_valid, 0);
    check("rst_right_re", right_re, 0);
    check("rst_down_valid", down_valid, 0);
    check("rst_down_re", down_re, 0);
    check("rst_down_im", down_im, 0);
    check("rst_w_count", w_count, 0);
    check("rst_w_in_ready", w_in_ready, 1);
    check("rst_err", err_no_weight, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    w_clear    = 1'b0;
    cycle();
  endtask

  task automatic push(input int re, input int im);
    in_valid   = 1'b0;
    w_clear    = 1'b0;
    w_in_valid = 1'b1;
    w_in_re    = 16'(re);
    w_in_im    = 16'(im);
    cycle();
    w_in_valid = 1'b0;
  endtask

  task automatic samp(input logic [1:0] m, input int lre, input int lim,
                      input longint ure, input longint uim);
    w_in_valid = 1'b0;
    w_clear    = 1'b0;
    mode       = m;
    in_valid   = 1'b1;
    left_re    = 16'(lre);
    left_im    = 16'(lim);
    up_re      = 40'(ure);
    up_im      = 40'(uim);
    cycle();
    in_valid   = 1'b0;
  endtask

  task automatic clear();
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    w_clear    = 1'b1;
    cycle();
    w_clear    = 1'b0;
  endtask

  initial begin
    longint big;
    rst        = 1'b1;
    mode       = 2'd0;
    in_valid   = 1'b0;
    left_re    = '0;
    left_im    = '0;
    up_re      = '0;
    up_im      = '0;
    w_in_re    = '0;
    w_in_im    = '0;
    w_in_valid = 1'b0;
    w_clear    = 1'b0;
    model_reset();
    #3;
    do_reset();
    idle();

    // Single weight, complex multiply then complex accumulate
    push(3, -2);
    samp(2'd1, 4, 5, 0, 0);
    check("cmul_dv_early", down_valid, 0);
    idle();
    check("cmul_dv", down_valid, 1);
    check("cmul_re", down_re, 22);
    check("cmul_im", down_im, 7);
    samp(2'd2, 4, 5, 100, -50);
    idle();
    check("cmac_re", down_re, 122);
    check("cmac_im", down_im, -43);
    idle();
    check("hold_dv", down_valid, 0);
    check("hold_re", down_re, 122);

    // Bank full, overflow push dropped, clear beats same-cycle push
    clear();
    for (int i = 0; i < DEPTH; i++) push(i + 1, -i);
    check("full_ready", w_in_ready, 0);
    push(99, 99);
    check("full_count", w_count, 16);
    w_clear    = 1'b1;
    w_in_valid = 1'b1;
    w_in_re    = 16'sd7;
    cycle();
    w_clear    = 1'b0;
    w_in_valid = 1'b0;
    check("clear_push_count", w_count, 0);

    // Cyclic reuse of three REAL weights
    push(1, 0);
    push(2, 0);
    push(3, 0);
    got.delete();
    for (int i = 0; i < 5; i++) samp(2'd0, 1, 0, 0, 0);
    idle();
    idle();
    check("real_seq_len", got.size(), 5);
    if (got.size() == 5) begin
      check("real_seq0", got[0], 1);
      check("real_seq1", got[1], 2);
      check("real_seq2", got[2], 3);
      check("real_seq3", got[3], 1);
      check("real_seq4", got[4], 2);
    end

    // Empty bank: zero weight and sticky error flag
    clear();
    samp(2'd2, 3, 4, 7, 8);
    idle();
    check("empty_re", down_re, 7);
    check("empty_im", down_im, 8);
    check("empty_err", err_no_weight, 1);
    idle();
    idle();
    check("empty_err_sticky", err_no_weight, 1);
    clear();
    check("empty_err_cleared", err_no_weight, 0);

    // Accumulator wraps rather than saturates
    push(1, 0);
    big = (longint'(1) <<< 39) - 1;
    samp(2'd0, 1, 0, big, 0);
    idle();
    check("wrap_re", down_re, -(longint'(1) <<< 39));
    check("wrap_im", down_im, 0);

    // Randomized traffic with mode changes, pushes and occasional clears
    clear();
    for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++)
      push(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      mode       = 2'($urandom_range(0, 3));
      left_re    = 16'($urandom);
      left_im    = 16'($urandom);
      up_re      = {8'($urandom), 32'($urandom)};
      up_im      = {8'($urandom), 32'($urandom)};
      w_in_valid = ($urandom_range(0, 7) == 0);
      w_in_re    = 16'($urandom);
      w_in_im    = 16'($urandom);
      w_clear    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    w_clear    = 1'b0;
    idle();
    idle();

    // Reset with samples in flight: nothing emerges afterwards
    push(5, 6);
    samp(2'd2, 9, 9, 1, 1);
    samp(2'd2, 9, 9, 1, 1);
    do_reset();
    got.delete();
    idle();
    idle();
    idle();
    check("rst_flush", got.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_cmac_cell.md
SA_CMAC_CELL -- requirements
Module: sa_cmac_cell

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed width of each real/imag component of left and weight operands.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, meaning signed width of each partial-sum component (up/down).
REQ-003 SHALL have parameter WBUF_DEPTH, default 16, meaning number of complex weights in the local weight bank (power of two, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports clk in 1 clock; rst in 1 reset.
REQ-006 SHALL have ports mode in 2 (0 REAL, 1 CMUL, 2 CMAC, 3 BYPASS); in_valid in 1; left_re/left_im in DATA_WIDTH each; up_re/up_im in ACC_WIDTH each.
REQ-007 SHALL have ports w_in_re/w_in_im in DATA_WIDTH each; w_in_valid in 1; w_in_ready out 1; w_clear in 1.
REQ-008 SHALL have ports right_re/right_im out DATA_WIDTH each; right_valid out 1; down_re/down_im out ACC_WIDTH each; down_valid out 1; w_count out $clog2(WBUF_DEPTH)+1; err_no_weight out 1.

Function
REQ-009 SHALL accept a weight when w_in_valid && w_in_ready, writing it at the write pointer and incrementing w_count.
REQ-010 SHALL drive w_in_ready = (w_count < WBUF_DEPTH), combinationally from registered count.
REQ-011 SHALL, on w_clear, zero w_count, write and read pointers; w_clear wins over a same-cycle push (push dropped).
REQ-012 SHALL, for each in_valid sample with mode != BYPASS, use the weight at rd_ptr, then advance rd_ptr modulo current w_count (cyclic reuse, weights not popped).
REQ-013 SHALL leave rd_ptr unchanged for BYPASS samples and for cycles without in_valid.
REQ-014 SHALL, when a weight-consuming sample arrives with w_count == 0, use weight (0,0) and set err_no_weight, which stays set until w_clear or rst.
REQ-015 SHALL register right_* <= left_*, right_valid <= in_valid, every cycle (1-cycle forward latency).
REQ-016 SHALL pipeline compute in two stages: stage 1 registers products, mode and up; stage 2 registers sums; down_valid asserts exactly 2 cycles after in_valid.
REQ-017 SHALL compute REAL: down_re = up_re + left_re*w_re, down_im = 0.
REQ-018 SHALL compute CMUL: down = left*w (complex), up ignored: re = lr*wr - li*wi, im = lr*wi + li*wr.
REQ-019 SHALL compute CMAC: down = up + left*w (complex); BYPASS: down = up.
REQ-020 SHALL sign-extend products (2*DATA_WIDTH) to ACC_WIDTH and wrap modulo 2^ACC_WIDTH on overflow (no saturation).
REQ-021 SHALL carry mode with each sample, so mode changes between consecutive samples take effect per sample without bubbles.
REQ-022 SHALL hold down_* at last value when down_valid is low.
REQ-023 SHALL permit push and consume in the same cycle; the consume uses w_count before the push.

Reset
REQ-024 SHALL, on rst, clear all outputs, pipeline registers, pointers, w_count and err_no_weight to 0, with w_in_ready = 1; weight bank contents need not be cleared.
REQ-025 SHALL discard in-flight samples on rst mid-operation (no down_valid after release for pre-reset samples).

Structure
REQ-026 SHALL place mode encodings and default width constants in shared package sa_pkg.
REQ-027 SHALL instantiate one sub-module sa_cmul (registered complex multiplier, stage 1).

Verification (DATA_WIDTH 16, ACC_WIDTH 40)
REQ-028 SHALL check reset: all outputs 0, w_in_ready 1, w_count 0.
REQ-029 SHALL check load w=(3,-2), CMUL, left=(4,5) -> down=(22,7), down_valid 2 cycles later; CMAC with up=(100,-50) -> (122,-43).
REQ-030 SHALL check push 16 weights -> w_in_ready low, 17th dropped; w_clear plus push same cycle -> w_count 0.
REQ-031 SHALL check REAL weights 1,2,3, five samples left=(1,0), up=0 -> down_re 1,2,3,1,2.
REQ-032 SHALL check empty bank CMAC up=(7,8) -> down=(7,8), err_no_weight 1 sticky until w_clear.
REQ-033 SHALL check wrap: REAL up_re=2^39-1, left=1, w=1 -> down_re=-2^39.
